// File: rtl/execute_muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
// Shift-add multiply (MUL_BITS per cycle), restoring divide (one bit per cycle), then a sign-fix cycle.
module execute_muldiv_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  input  logic             read_hilo,
  output logic             busy,
  output logic             done,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [6:0] MulCnt = 7'(WIDTH / MUL_BITS);
  localparam logic [6:0] DivCnt = 7'(WIDTH);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e                 state_q, state_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       mcand_q, mcand_d;
  logic [WIDTH-1:0]       rs_q, rs_d;
  logic [6:0]             cnt_q, cnt_d;
  logic                   is_div_q, is_div_d;
  logic                   macc_q, macc_d;
  logic                   msub_q, msub_d;
  logic                   neg_q, neg_d;
  logic                   rem_neg_q, rem_neg_d;
  logic                   div_zero_q, div_zero_d;
  logic                   ovf_q, ovf_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;
  logic                   done_q, done_d;

  // Operand decode at accept time
  logic                   op_signed;
  logic                   op_is_div;
  logic [WIDTH-1:0]       rs_mag;
  logic [WIDTH-1:0]       rt_mag;

  always_comb begin
    op_signed = ~op[0];
    op_is_div = (op[2:1] == 2'b01);
    rs_mag    = (op_signed && rs[WIDTH-1]) ? (~rs + 1'b1) : rs;
    rt_mag    = (op_signed && rt[WIDTH-1]) ? (~rt + 1'b1) : rt;
  end

  // One multiply step: add mcand * low digit into the upper half, shift right by MUL_BITS
  logic [MUL_BITS-1:0]       mul_digit;
  logic [WIDTH+MUL_BITS-1:0] mul_pp;
  logic [WIDTH+MUL_BITS-1:0] mul_sum;
  logic [2*WIDTH-1:0]        mul_next;

  always_comb begin
    mul_digit = acc_q[MUL_BITS-1:0];
    mul_pp    = '0;
    for (int i = 0; i < int'(MUL_BITS); i++) begin
      if (mul_digit[i]) begin
        mul_pp = mul_pp + ({{MUL_BITS{1'b0}}, mcand_q} << i);
      end
    end
    mul_sum = {{MUL_BITS{1'b0}}, acc_q[2*WIDTH-1:WIDTH]} + mul_pp;
  end

  if (MUL_BITS < WIDTH) begin : g_mul_shift
    assign mul_next = {mul_sum, acc_q[WIDTH-1:MUL_BITS]};
  end else begin : g_mul_full
    assign mul_next = mul_sum;
  end

  // One restoring-divide step: acc holds {remainder, remaining dividend / quotient bits}
  logic [WIDTH:0]     div_trial;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_trial[WIDTH-1:0] - mcand_q;
    div_ge    = (div_trial >= {1'b0, mcand_q});
    div_rem   = div_ge ? div_diff : div_trial[WIDTH-1:0];
    div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};
  end

  // Sign fix-up and HI/LO results
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] hilo_old;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quo_res;
  logic [WIDTH-1:0]   rem_res;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    prod     = neg_q ? (~acc_q + 1'b1) : acc_q;
    hilo_old = {hi_q, lo_q};
    if (!macc_q) begin
      mul_res = prod;
    end else if (msub_q) begin
      mul_res = hilo_old - prod;
    end else begin
      mul_res = hilo_old + prod;
    end
    quo_res = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_res = rem_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    if (!is_div_q) begin
      fix_hi = mul_res[2*WIDTH-1:WIDTH];
      fix_lo = mul_res[WIDTH-1:0];
    end else if (div_zero_q) begin
      fix_hi = rs_q;
      fix_lo = '1;
    end else if (ovf_q) begin
      fix_hi = '0;
      fix_lo = rs_q;
    end else begin
      fix_hi = rem_res;
      fix_lo = quo_res;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    rs_d       = rs_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    macc_d     = macc_q;
    msub_d     = msub_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start && !flush) begin
          if (op == 4'd8) begin
            hi_d = rs;
          end else if (op == 4'd9) begin
            lo_d = rs;
          end else if (!op[3]) begin
            is_div_d   = op_is_div;
            macc_d     = op[2];
            msub_d     = op[1];
            neg_d      = op_signed && (rs[WIDTH-1] ^ rt[WIDTH-1]);
            rem_neg_d  = op_signed && rs[WIDTH-1];
            div_zero_d = (rt == '0);
            ovf_d      = op_signed && (rs == {1'b1, {(WIDTH-1){1'b0}}}) && (rt == '1);
            rs_d       = rs;
            if (op_is_div) begin
              acc_d   = {{WIDTH{1'b0}}, rs_mag};
              mcand_d = rt_mag;
              cnt_d   = DivCnt;
              state_d = StDiv;
            end else begin
              acc_d   = {{WIDTH{1'b0}}, rt_mag};
              mcand_d = rs_mag;
              cnt_d   = MulCnt;
              state_d = StMul;
            end
          end
        end
      end
      StMul: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d = mul_next;
          cnt_d = cnt_q - 7'd1;
          if (cnt_q == 7'd1) state_d = StFix;
        end
      end
      StDiv: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d = div_next;
          cnt_d = cnt_q - 7'd1;
          if (cnt_q == 7'd1) state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!flush) begin
          hi_d   = fix_hi;
          lo_d   = fix_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      mcand_q    <= '0;
      rs_q       <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      macc_q     <= 1'b0;
      msub_q     <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      rs_q       <= rs_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      macc_q     <= macc_d;
      msub_q     <= msub_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign stall_req = busy & (read_hilo | start);
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Directed bench for execute_muldiv_unit: one MUL_BITS=1 instance and one MUL_BITS=4 instance.
module tb_execute_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, flush, read_hilo;
  logic [3:0]  op;
  logic [31:0] rs, rt;
  logic        busy, done, stall_req;
  logic [31:0] hi, lo;

  logic        start4, flush4, read_hilo4;
  logic [3:0]  op4;
  logic [31:0] rs4, rt4;
  logic        busy4, done4, stall_req4;
  logic [31:0] hi4, lo4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  execute_muldiv_unit #(.WIDTH(32), .MUL_BITS(1)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .flush(flush), .read_hilo(read_hilo), .busy(busy), .done(done),
    .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  execute_muldiv_unit #(.WIDTH(32), .MUL_BITS(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .op(op4), .rs(rs4), .rt(rt4),
    .flush(flush4), .read_hilo(read_hilo4), .busy(busy4), .done(done4),
    .stall_req(stall_req4), .hi(hi4), .lo(lo4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue an iterative op, measure the done cycle (cycle 1 = first cycle after the accept edge)
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int exp_cyc, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input string tag);
    int cyc;
    cyc = -1;
    op = o; rs = a; rt = b; start = 1'b1;
    step();
    start = 1'b0;
    check($sformatf("%s busy", tag), 64'(busy), 64'd1);
    for (int k = 1; k <= 100; k++) begin
      if (done) begin
        cyc = k;
        break;
      end
      step();
    end
    check($sformatf("%s done_cycle", tag), 64'(cyc), 64'(exp_cyc));
    check($sformatf("%s hi", tag), 64'(hi), 64'(exp_hi));
    check($sformatf("%s lo", tag), 64'(lo), 64'(exp_lo));
    step();
    check($sformatf("%s done_pulse", tag), 64'(done), 64'd0);
  endtask

  task automatic move_to(input logic [3:0] o, input logic [31:0] a, input string tag);
    op = o; rs = a; start = 1'b1;
    step();
    start = 1'b0;
    check($sformatf("%s busy", tag), 64'(busy), 64'd0);
    check($sformatf("%s done", tag), 64'(done), 64'd0);
  endtask

  initial begin
    int  cyc4;
    logic seen_done;
    reset = 1'b1; start = 1'b0; flush = 1'b0; read_hilo = 1'b0;
    op = '0; rs = '0; rt = '0;
    start4 = 1'b0; flush4 = 1'b0; read_hilo4 = 1'b0; op4 = '0; rs4 = '0; rt4 = '0;

    repeat (2) @(posedge clk);
    #1;
    read_hilo = 1'b1;
    #1;
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset stall", 64'(stall_req), 64'd0);
    read_hilo = 1'b0;
    step();
    reset = 1'b0;

    run_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    run_op(4'd2, 32'hFFFF_FFF9, 32'h0000_0002, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2");
    run_op(4'd3, 32'h0000_0005, 32'h0000_0000, 34, 32'h0000_0005, 32'hFFFF_FFFF, "divu_by0");
    run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h8000_0000, "div_ovf");
    run_op(4'd0, 32'hFFFF_FFFD, 32'h0000_0005, 34, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg3_5");

    move_to(4'd9, 32'hFFFF_FFFF, "mtlo");
    check("mtlo lo", 64'(lo), 64'hFFFF_FFFF);
    move_to(4'd8, 32'h0000_0000, "mthi");
    check("mthi hi", 64'(hi), 64'd0);
    run_op(4'd4, 32'd1, 32'd1, 34, 32'h0000_0001, 32'h0000_0000, "madd");
    run_op(4'd6, 32'd1, 32'd1, 34, 32'h0000_0000, 32'hFFFF_FFFF, "msub");

    // DIVU flushed in cycle 10; stall and ignored start while busy
    op = 4'd3; rs = 32'd100; rt = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    step();
    read_hilo = 1'b1;
    #1;
    check("stall read_hilo", 64'(stall_req), 64'd1);
    read_hilo = 1'b0;
    op = 4'd8; rs = 32'h0000_1234; start = 1'b1;
    #1;
    check("stall start", 64'(stall_req), 64'd1);
    step();
    start = 1'b0;
    #1;
    check("busy start ignored hi", 64'(hi), 64'd0);
    check("no stall idle inputs", 64'(stall_req), 64'd0);
    repeat (7) step();
    check("flush pre busy", 64'(busy), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush done", 64'(done), 64'd0);
    check("flush hi", 64'(hi), 64'd0);
    check("flush lo", 64'(lo), 64'hFFFF_FFFF);
    seen_done = 1'b0;
    repeat (40) begin
      step();
      if (done) seen_done = 1'b1;
    end
    check("flush no_done", 64'(seen_done), 64'd0);
    check("flush lo late", 64'(lo), 64'hFFFF_FFFF);

    // flush beats start in IDLE, MTLO included
    flush = 1'b1; start = 1'b1; op = 4'd9; rs = 32'hAAAA_5555;
    step();
    flush = 1'b0; start = 1'b0;
    check("flush+mtlo lo", 64'(lo), 64'hFFFF_FFFF);
    check("flush+mtlo busy", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a MULT
    op = 4'd0; rs = 32'd7; rt = 32'd9; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    check("mid mult busy", 64'(busy), 64'd1);
    read_hilo = 1'b1;
    reset = 1'b1;
    #1;
    check("async reset hi", 64'(hi), 64'd0);
    check("async reset lo", 64'(lo), 64'd0);
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset done", 64'(done), 64'd0);
    check("async reset stall", 64'(stall_req), 64'd0);
    read_hilo = 1'b0;
    step();
    reset = 1'b0;
    run_op(4'd1, 32'd3, 32'd4, 34, 32'h0000_0000, 32'h0000_000C, "multu_3x4");

    // Four multiplier bits per cycle
    cyc4 = -1;
    op4 = 4'd1; rs4 = 32'hFFFF_FFFF; rt4 = 32'hFFFF_FFFF; start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (done4) begin
        cyc4 = k;
        break;
      end
      step();
    end
    check("mb4 done_cycle", 64'(cyc4), 64'd10);
    check("mb4 hi", 64'(hi4), 64'hFFFF_FFFE);
    check("mb4 lo", 64'(lo4), 64'h0000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/execute_muldiv_unit.md
EXECUTE_MULDIV_UNIT -- requirements
Module: execute_muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width; hi and lo are each WIDTH bits; legal values 8, 16, 32, 64.
REQ-002 Parameter MUL_BITS, default 1: multiplier bits retired per cycle; legal values 1, 2, 4, 8; must divide WIDTH.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: request to begin the operation given by op.
REQ-006 Port op, input, 4: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 MTHI, 9 MTLO; 10-15 no-op.
REQ-007 Port rs, input, WIDTH: multiplicand/dividend, or source for MTHI/MTLO.
REQ-008 Port rt, input, WIDTH: multiplier/divisor.
REQ-009 Port flush, input, 1: nullify the in-flight operation.
REQ-010 Port read_hilo, input, 1: the instruction in execute reads hi or lo.
REQ-011 Port busy, output, 1: an iterative operation is in progress.
REQ-012 Port done, output, 1: one-cycle pulse; hi/lo hold a new result.
REQ-013 Port stall_req, output, 1: stall request to the pipeline.
REQ-014 Port hi, output, WIDTH: architectural HI register.
REQ-015 Port lo, output, WIDTH: architectural LO register.

Function
REQ-016 States: IDLE, MUL, DIV, FIX; busy shall be 1 exactly in MUL, DIV and FIX.
REQ-017 start is accepted only in IDLE with flush=0; start in any other state is ignored.
REQ-018 Accepting MTHI/MTLO shall write rs to hi/lo at that edge; the unit stays in IDLE and done stays 0.
REQ-019 Accepting ops 0-7 shall latch operand magnitudes, the sign/op flags and the iteration count, then enter MUL (ops 0,1,4-7) or DIV (ops 2,3).
REQ-020 MUL shall run WIDTH/MUL_BITS cycles of shift-add on unsigned magnitudes.
REQ-021 DIV shall run WIDTH cycles of restoring division on unsigned magnitudes.
REQ-022 FIX shall last one cycle and write hi/lo at its closing edge.
REQ-023 FIX shall apply signs: product negated if operand signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
REQ-024 FIX for MULT/MULTU shall set {hi,lo} = the 2*WIDTH-bit product.
REQ-025 FIX for MADD*/MSUB* shall add the product to, or subtract it from, the old {hi,lo}, modulo 2^(2*WIDTH).
REQ-026 FIX for DIV/DIVU shall set lo = quotient and hi = remainder.
REQ-027 Latency from the accept edge to hi/lo valid: WIDTH/MUL_BITS+1 cycles for multiply, WIDTH+1 cycles for divide.
REQ-028 done shall be 1 for the single cycle following the FIX write; the unit is in IDLE during that cycle and may accept a new start.
REQ-029 Divide by zero: lo = all ones, hi = rs; latency unchanged.
REQ-030 Signed overflow (most-negative / -1): lo = rs, hi = 0.
REQ-031 stall_req = busy AND (read_hilo OR start), combinational.
REQ-032 flush=1 in MUL, DIV or FIX shall return the unit to IDLE at the next edge; hi/lo are unchanged and done is not asserted.
REQ-033 flush and start together in IDLE: flush wins; nothing is accepted, MTHI/MTLO included.
REQ-034 hi/lo change only through REQ-018 and REQ-022.

Reset
REQ-035 Asserting reset shall immediately force state = IDLE and hi = lo = 0, with busy, done and stall_req at 0, including when reset arrives mid-operation.
REQ-036 At reset all internal iteration registers shall clear; the first edge after reset deasserts may accept a start.

Verification (WIDTH=32, MUL_BITS=1 unless stated)
REQ-037 MULTU, rs = rt = 0xFFFFFFFF -> done in cycle 34 after accept; hi = 0xFFFFFFFE, lo = 0x00000001; repeat with MUL_BITS=4 -> done in cycle 10.
REQ-038 DIV, rs = 0xFFFFFFF9 (-7), rt = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF, done in cycle 34.
REQ-039 DIVU, rs = 5, rt = 0 -> lo = 0xFFFFFFFF, hi = 5; DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
REQ-040 MTLO 0xFFFFFFFF, MTHI 0, then MADD rs = rt = 1 -> hi = 1, lo = 0; then MSUB rs = rt = 1 -> hi = 0, lo = 0xFFFFFFFF.
REQ-041 DIVU started, flush in cycle 10 -> busy = 0 next cycle, hi/lo unchanged, no done; read_hilo or start while busy -> stall_req = 1.
REQ-042 reset asserted mid-MULT -> immediately hi = lo = 0 and busy = 0; a new MULTU 3*4 started after reset deasserts -> lo = 12, hi = 0.
